// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one multiplier/quotient bit per clock, START/BUSY/VALID handshake, KILL flush.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             KILL,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   result_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               sa_q, sb_q, dz_q, ovf_q, busy_q, valid_q;

    logic               is_div, a_sgn, b_sgn, a_neg, b_neg, dz_d, ovf_d, early_d;
    logic [WIDTH-1:0]   a_abs, b_abs;

    always_comb begin
        is_div  = SELECT[2];
        a_sgn   = is_div ? ~SELECT[0] : (SELECT[1:0] == 2'b01 || SELECT[1:0] == 2'b10);
        b_sgn   = is_div ? ~SELECT[0] : (SELECT[1:0] == 2'b01);
        a_neg   = a_sgn & DATA1[WIDTH-1];
        b_neg   = b_sgn & DATA2[WIDTH-1];
        // most-negative input negates to itself, read back as unsigned 2^(WIDTH-1)
        a_abs   = a_neg ? -DATA1 : DATA1;
        b_abs   = b_neg ? -DATA2 : DATA2;
        dz_d    = (DATA2 == '0);
        ovf_d   = ~SELECT[0] && (DATA1 == MOST_NEG) && (DATA2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early_d = is_div ? (dz_d | ovf_d) : (DATA1 == '0 || DATA2 == '0);
`else
        early_d = 1'b0;
`endif
    end

    // One iteration: shift-add multiply or restoring divide step
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   rem_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            // shifted remainder < 2*divisor, so the difference's top bit is the borrow
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            rem_d = rem_q;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd, result_d;

    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rmd  = sa_q ? -rem_q : rem_q;
        case (op_q)
            3'b000:                 result_d = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         result_d = dz_q ? '1 : (ovf_q ? a_q : quo);
            default:                result_d = dz_q ? a_q : (ovf_q ? '0 : rmd);
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            opnd_q   <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (KILL) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (START) begin
                        op_q   <= SELECT;
                        a_q    <= DATA1;
                        sa_q   <= a_neg;
                        sb_q   <= b_neg;
                        dz_q   <= dz_d;
                        ovf_q  <= ovf_d;
                        rem_q  <= '0;
                        cnt_q  <= CW'(WIDTH - 1);
                        busy_q <= 1'b1;
                        opnd_q <= is_div ? b_abs : a_abs;
                        if (early_d && !is_div)
                            acc_q <= '0;
                        else
                            acc_q <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                        state_q <= early_d ? FIX : CALC;
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0)
                            state_q <= FIX;
                    end
                    FIX: begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at START, checked with latency when VALID pulses.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         CLK = 1'b0;
    logic         RESET_N, START, KILL, BUSY, VALID;
    logic [2:0]   SELECT;
    logic [W-1:0] DATA1, DATA2, RESULT;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
    );

    typedef struct {
        logic [W-1:0] res;
        int           e0;
        int           lat;
        string        tag;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] last_exp = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] ea, eb, p;
        int ia, ib;
        ea = (sel == 3'b001 || sel == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (sel == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        ia = a;
        ib = b;
        case (sel)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == '0) return '1;
                if (a == MIN && b == '1) return a;
                return ia / ib;
            end
            3'b101: return (b == '0) ? '1 : a / b;
            3'b110: begin
                if (b == '0) return a;
                if (a == MIN && b == '1) return '0;
                return ia % ib;
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (sel[2]) begin
            if (b == '0 || (!sel[0] && a == MIN && b == '1)) return 1;
        end else if (a == '0 || b == '0) begin
            return 1;
        end
`endif
        return W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return MIN;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge CLK) begin
        if (RESET_N && VALID === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", {31'b0, VALID}, '0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_res"}, RESULT, e.res);
                chk({e.tag, "_lat"}, W'(cyc - e.e0), W'(e.lat));
                chk({e.tag, "_busyv"}, {31'b0, BUSY}, '0);
                last_exp = e.res;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_raw(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
        exp_t e;
        e.res = exp; e.e0 = cyc + 1; e.lat = exp_lat(sel, a, b); e.tag = tag;
        sbq.push_back(e);
        start_raw(sel, a, b);
        chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sbq.size() != 0 && n < bound) begin
            step();
            n++;
        end
        if (sbq.size() != 0) begin
            chk("timeout_pending", W'(sbq.size()), '0);
            sbq.delete();
        end
    endtask

    task automatic run(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string tag);
        issue(sel, a, b, exp, tag);
        drain(100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; START = 1'b0; KILL = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
        #12;
        chk("rst_busy", {31'b0, BUSY}, '0);
        chk("rst_valid", {31'b0, VALID}, '0);
        chk("rst_result", RESULT, '0);
        RESET_N = 1'b1;
        step();

        run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run(3'b011, '1, '1, 32'hFFFF_FFFE, "mulhu");
        run(3'b001, '1, '1, 32'h0000_0000, "mulh");
        run(3'b010, '1, 32'd2, 32'hFFFF_FFFF, "mulhsu");
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
        run(3'b101, 32'd100, 32'd7, 32'd14, "divu");
        run(3'b111, 32'd100, 32'd7, 32'd2, "remu");
        run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run(3'b110, 32'd5, 32'd0, 32'd5, "rem_by0");
        run(3'b100, MIN, '1, MIN, "div_ovf");
        run(3'b110, MIN, '1, 32'd0, "rem_ovf");
        run(3'b000, 32'd0, 32'd12345, 32'd0, "mul_zero");

        // KILL ten cycles into a divide, then restart one cycle later
        start_raw(3'b100, 32'hFFFF_FC18, 32'd7);
        repeat (9) step();
        KILL = 1'b1;
        step();
        KILL = 1'b0;
        chk("kill_busy", {31'b0, BUSY}, '0);
        chk("kill_result", RESULT, last_exp);
        step();
        run(3'b100, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, "after_kill");
        repeat (40) step();

        // KILL wins over START in the same cycle
        KILL = 1'b1;
        start_raw(3'b000, 32'd3, 32'd4);
        KILL = 1'b0;
        chk("kill_vs_start_busy", {31'b0, BUSY}, '0);
        repeat (40) step();
        chk("kill_vs_start_result", RESULT, last_exp);

        // asynchronous reset mid-multiply
        start_raw(3'b000, 32'd3, 32'd5);
        repeat (5) step();
        #2 RESET_N = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, BUSY}, '0);
        chk("midrst_valid", {31'b0, VALID}, '0);
        chk("midrst_result", RESULT, '0);
        last_exp = '0;
        #3 RESET_N = 1'b1;
        step();
        repeat (40) step();
        chk("postrst_result", RESULT, '0);

        // back-to-back: second START in the VALID cycle of the first
        issue(3'b000, 32'd1000, 32'd1000, 32'd1000000, "b2b_first");
        for (int k = 0; k < 40; k++) begin
            step();
            if (VALID) break;
        end
        chk("b2b_valid_seen", {31'b0, VALID}, 32'd1);
        issue(3'b111, 32'd1000, 32'd33, 32'd10, "b2b_second");
        drain(100);

        // START pulses while busy must be ignored
        issue(3'b101, 32'd100, 32'd7, 32'd14, "ign");
        for (int k = 0; k < 5; k++) begin
            step();
            start_raw(3'b000, 32'($urandom), 32'($urandom));
        end
        drain(100);
        repeat (40) step();

        for (int i = 0; i < 24; i++) begin
            logic [2:0]   s;
            logic [W-1:0] a, b;
            s = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run(s, a, b, model(s, a, b), $sformatf("rnd%0d_op%0d", i, s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
